dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shared data-memory front end that sits directly downstream of every processor core's data port.
- Collects each core's memory request (Mem_Ctrl, DAddress, Ddout) and arbitrates round-robin between cores.
- Drives one single-port synchronous RAM and returns read data (Ddin) plus a one-cycle acknowledge (acq) to the requesting core.
- One transaction is in flight at a time; cores stall in their control units until acq.

Parameters:
- NUM_CORES, 4, number of core ports served (1..8).
- AW, 8, address width; matches core DAddress.
- DW, 8, data width; matches core Ddin/Ddout.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- core_mem_ctrl  in  4*NUM_CORES  per-core Mem_Ctrl; slice i = bits [4i+3:4i].
- core_addr  in  AW*NUM_CORES  per-core DAddress.
- core_wdata  in  DW*NUM_CORES  per-core Ddout.
- core_ddin  out  DW*NUM_CORES  per-core read data (to core Ddin).
- core_acq  out  NUM_CORES  per-core acknowledge (to core acq), one-cycle pulse.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DW  RAM read data; registered, valid one cycle after the address is presented.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Request decode per core, using Mem_Ctrl[1:0]:
  - 2'b01 = read, 2'b10 = write.
  - 2'b00 and 2'b11 = no request.
  - Mem_Ctrl[3:2] are ignored.
- Reset (asynchronous):
  - state=IDLE; core_acq=0; ram_we=0; ram_addr=0; ram_din=0; busy=0.
  - All core_ddin slices = 0; rr_last=NUM_CORES-1, so core 0 has first priority.
  - cooldown mask = 0.
- Eligibility: core i is eligible when it holds a valid request and cooldown[i]=0.
- FSM states: IDLE, ACCESS, RWAIT, ACK.
  - IDLE:
    - If any core is eligible, grant the first eligible core searching rr_last+1, rr_last+2, ... modulo NUM_CORES.
    - Latch g, op, addr and wdata into internal registers; set rr_last=g; go to ACCESS.
    - If no core is eligible, stay in IDLE.
  - ACCESS:
    - ram_addr = latched addr.
    - Write: ram_din = latched wdata and ram_we=1 for exactly this cycle, then go to ACK.
    - Read: ram_we=0, then go to RWAIT.
  - RWAIT: capture ram_dout into core_ddin slice g; go to ACK.
  - ACK:
    - core_acq[g]=1 for this single cycle; set cooldown[g]=1; go to IDLE.
    - All other core_acq bits stay 0.
- Latency, counted from the IDLE cycle in which the grant is taken (cycle t):
  - write: ram_we at t+1, acq at t+2.
  - read: RAM address at t+1, data captured at t+2, acq at t+3. core_ddin[g] is already valid while acq is high.
- Cooldown:
  - cooldown[i] clears on the cycle after it was set, i.e. in the IDLE cycle following ACK, where core i is ineligible.
  - This prevents double service while the core's control unit leaves its wait state.
  - A core still requesting after that cycle is treated as a new request.
- Data holding:
  - core_ddin slices hold their value until the next read completes for the same core.
  - Writes never change core_ddin.
- Request changes:
  - Changes to core inputs after the grant are ignored; the latched values are used.
  - A request dropped before the grant is simply not served.
- Reset mid-transaction:
  - Any state returns to IDLE immediately; ram_we drops asynchronously.
  - No acq is issued for the aborted transaction.
- Maximum throughput: one write per 3 cycles or one read per 4 cycles; there is no back-to-back pipelining.
- Fairness: with all cores requesting continuously, grants rotate 0,1,2,...,NUM_CORES-1,0, ...

Test Plan:
- Single write: core 1 drives ctrl=4'h2, addr=8'h10, wdata=8'hA5.
  - Required: ram_we=1 with ram_addr=8'h10 and ram_din=8'hA5 exactly 1 cycle after the grant.
  - core_acq=4'b0010 for one cycle, 2 cycles after the grant; no other bits ever set.
- Single read after the write: core 3 drives ctrl=4'h1, addr=8'h10.
  - Required: core_acq[3] pulses 3 cycles after the grant with core_ddin slice 3 = 8'hA5.
  - Slices 0–2 are unchanged.
- Contention: cores 0, 2 and 3 assert reads in the same cycle from reset.
  - Required grant order 0, 2, 3; acq pulses 4 cycles apart; busy stays high except for single IDLE cycles between transactions.
- Held request (cooldown): core 0 keeps ctrl=4'h1 asserted for 2 cycles after its acq while no other core requests.
  - Required: no grant in the cycle after acq; a new grant in the following cycle.
  - Exactly two acq pulses in total.
- Ignored encodings: ctrl=4'h0, 4'h3 and 4'hC on all cores.
  - Required: busy=0, ram_we=0, core_acq=0 throughout.
- Reset mid-read: assert RST while in RWAIT.
  - Required: same-cycle state=IDLE, all outputs return to reset values, no acq issued.
  - After release, core 0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of core-side request/response signals and the RAM port for dmem_arbiter.
// Flat per-core vectors: slice i of each field belongs to core i.
interface dmem_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 8,
    parameter int DW        = 8
);
    logic [4*NUM_CORES-1:0]  core_mem_ctrl;
    logic [AW*NUM_CORES-1:0] core_addr;
    logic [DW*NUM_CORES-1:0] core_wdata;
    logic [DW*NUM_CORES-1:0] core_ddin;
    logic [NUM_CORES-1:0]    core_acq;
    logic [AW-1:0]           ram_addr;
    logic [DW-1:0]           ram_din;
    logic                    ram_we;
    logic [DW-1:0]           ram_dout;
    logic                    busy;

    // arbiter side
    modport slave (
        input  core_mem_ctrl, core_addr, core_wdata, ram_dout,
        output core_ddin, core_acq, ram_addr, ram_din, ram_we, busy
    );

    // cores + RAM side
    modport master (
        output core_mem_ctrl, core_addr, core_wdata, ram_dout,
        input  core_ddin, core_acq, ram_addr, ram_din, ram_we, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter letting NUM_CORES core data ports share one single-port
// synchronous RAM, one transaction at a time, with a one-cycle acq per request.
module dmem_req_decode (
    input  logic [3:0] ctrl,
    input  logic       cool,
    output logic       elig,
    output logic       wr
);
    logic rd;
    assign rd   = (ctrl[1:0] == 2'b01);
    assign wr   = (ctrl[1:0] == 2'b10);
    assign elig = (rd | wr) & ~cool;
endmodule

module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 8,
    parameter int DW        = 8
) (
    input logic           CLK,
    input logic           RST,
    dmem_arbiter_if.slave bus
);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, ACK} state_t;

    typedef struct packed {
        logic [GW-1:0] g;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t                        state, state_nxt;
    req_t                          req_q;
    logic [GW-1:0]                 rr_last;
    logic [NUM_CORES-1:0]          cooldown;
    logic [NUM_CORES-1:0][DW-1:0]  ddin_q;
    logic [NUM_CORES-1:0]          elig, is_wr;
    logic                          grant_vld;
    logic [GW-1:0]                 grant_idx;
    int                            idx;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_dec
        dmem_req_decode u_dec (
            .ctrl (bus.core_mem_ctrl[4*i +: 4]),
            .cool (cooldown[i]),
            .elig (elig[i]),
            .wr   (is_wr[i])
        );
    end

    // First eligible core after the last one served, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = (int'(rr_last) + k) % NUM_CORES;
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = req_q.wr ? ACK : RWAIT;
            RWAIT:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            req_q    <= '0;
            rr_last  <= GW'(NUM_CORES - 1);
            cooldown <= '0;
            ddin_q   <= '0;
        end else begin
            state    <= state_nxt;
            // cooldown lives for exactly the IDLE cycle after ACK
            cooldown <= '0;
            case (state)
                IDLE: if (grant_vld) begin
                    req_q.g     <= grant_idx;
                    req_q.wr    <= is_wr[grant_idx];
                    req_q.addr  <= bus.core_addr[grant_idx*AW +: AW];
                    req_q.wdata <= bus.core_wdata[grant_idx*DW +: DW];
                    rr_last     <= grant_idx;
                end
                RWAIT:   ddin_q[req_q.g]   <= bus.ram_dout;
                ACK:     cooldown[req_q.g] <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.core_acq = '0;
        if (state == ACK) bus.core_acq[req_q.g] = 1'b1;
    end

    assign bus.core_ddin = ddin_q;
    assign bus.ram_addr  = req_q.addr;
    assign bus.ram_din   = req_q.wdata;
    assign bus.ram_we    = (state == ACCESS) && req_q.wr;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural sync RAM plus per-scenario tasks
// with hand-computed cycle-by-cycle expectations.
module tb_dmem_arbiter;
    localparam int N = 4, AW = 8, DW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter_if #(.NUM_CORES(N), .AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.NUM_CORES(N), .AW(AW), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    logic [DW-1:0] mem [256];
    always @(posedge CLK) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.ram_we); end
        checks++; if (bus.ram_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", bus.ram_addr); end
        checks++; if (bus.ram_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", bus.ram_din); end
        checks++; if (bus.core_acq !== 4'b0000) begin errors++; $display("FAIL reset_acq got %b want 0000", bus.core_acq); end
        checks++; if (bus.core_ddin !== 32'h0) begin errors++; $display("FAIL reset_ddin got %h want 0", bus.core_ddin); end
        tick();
        RST = 1'b0;
    endtask

    task automatic test_write;
        bus.core_mem_ctrl[7:4] = 4'h2;
        bus.core_addr[15:8]    = 8'h10;
        bus.core_wdata[15:8]   = 8'hA5;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_t_busy got %b want 0", bus.busy); end
        tick();
        // grant taken: later input changes must not leak through
        bus.core_mem_ctrl[7:4] = 4'h0;
        bus.core_addr[15:8]    = 8'hFF;
        bus.core_wdata[15:8]   = 8'h00;
        checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL wr_t1_we got %b want 1", bus.ram_we); end
        checks++; if (bus.ram_addr !== 8'h10) begin errors++; $display("FAIL wr_t1_addr got %h want 10", bus.ram_addr); end
        checks++; if (bus.ram_din !== 8'hA5) begin errors++; $display("FAIL wr_t1_din got %h want a5", bus.ram_din); end
        checks++; if (bus.core_acq !== 4'b0000) begin errors++; $display("FAIL wr_t1_acq got %b want 0000", bus.core_acq); end
        tick();
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL wr_t2_we got %b want 0", bus.ram_we); end
        checks++; if (bus.core_acq !== 4'b0010) begin errors++; $display("FAIL wr_t2_acq got %b want 0010", bus.core_acq); end
        tick();
        checks++; if (bus.core_acq !== 4'b0000) begin errors++; $display("FAIL wr_t3_acq got %b want 0000", bus.core_acq); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_t3_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_read;
        bus.core_mem_ctrl[15:12] = 4'h1;
        bus.core_addr[31:24]     = 8'h10;
        tick();
        bus.core_mem_ctrl[15:12] = 4'h0;
        checks++; if (bus.ram_addr !== 8'h10) begin errors++; $display("FAIL rd_t1_addr got %h want 10", bus.ram_addr); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rd_t1_we got %b want 0", bus.ram_we); end
        tick();
        checks++; if (bus.core_acq !== 4'b0000) begin errors++; $display("FAIL rd_t2_acq got %b want 0000", bus.core_acq); end
        tick();
        checks++; if (bus.core_acq !== 4'b1000) begin errors++; $display("FAIL rd_t3_acq got %b want 1000", bus.core_acq); end
        checks++; if (bus.core_ddin !== 32'hA5000000) begin errors++; $display("FAIL rd_t3_ddin got %h want a5000000", bus.core_ddin); end
        tick();
        checks++; if (bus.core_acq !== 4'b0000) begin errors++; $display("FAIL rd_t4_acq got %b want 0000", bus.core_acq); end
    endtask

    task automatic do_write(input int c, input logic [7:0] a, input logic [7:0] d);
        bit got = 1'b0;
        bus.core_mem_ctrl[4*c +: 4] = 4'h2;
        bus.core_addr[8*c +: 8]     = a;
        bus.core_wdata[8*c +: 8]    = d;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (bus.core_acq[c]) got = 1'b1;
        end
        bus.core_mem_ctrl[4*c +: 4] = 4'h0;
        checks++; if (!got) begin errors++; $display("FAIL preload_timeout core %0d got no acq want acq", c); end
        tick();
    endtask

    task automatic test_contention;
        logic [3:0] exp_acq;
        logic       exp_busy;
        do_write(0, 8'h20, 8'h11);
        do_write(2, 8'h30, 8'h22);
        do_write(3, 8'h40, 8'h33);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus.core_mem_ctrl = 16'h1101;
        bus.core_addr     = 32'h40300020;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            exp_acq  = (cyc == 3) ? 4'b0001 : (cyc == 7) ? 4'b0100 : (cyc == 11) ? 4'b1000 : 4'b0000;
            exp_busy = (cyc % 4) != 0;
            checks++; if (bus.core_acq !== exp_acq) begin errors++; $display("FAIL cont_acq c%0d got %b want %b", cyc, bus.core_acq, exp_acq); end
            checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL cont_busy c%0d got %b want %b", cyc, bus.busy, exp_busy); end
            for (int i = 0; i < N; i++)
                if (bus.core_acq[i]) bus.core_mem_ctrl[4*i +: 4] = 4'h0;
            tick();
        end
        checks++; if (bus.core_ddin !== 32'h33220011) begin errors++; $display("FAIL cont_ddin got %h want 33220011", bus.core_ddin); end
    endtask

    task automatic test_cooldown;
        int         n_acq = 0;
        logic [3:0] exp_acq;
        logic       exp_busy;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 0) begin bus.core_mem_ctrl[3:0] = 4'h1; bus.core_addr[7:0] = 8'h20; end
            if (cyc == 6) bus.core_mem_ctrl[3:0] = 4'h0;
            exp_acq  = (cyc == 3 || cyc == 8) ? 4'b0001 : 4'b0000;
            exp_busy = (cyc >= 1 && cyc <= 3) || (cyc >= 6 && cyc <= 8);
            if (bus.core_acq[0]) n_acq++;
            checks++; if (bus.core_acq !== exp_acq) begin errors++; $display("FAIL cool_acq c%0d got %b want %b", cyc, bus.core_acq, exp_acq); end
            checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL cool_busy c%0d got %b want %b", cyc, bus.busy, exp_busy); end
            tick();
        end
        checks++; if (n_acq !== 2) begin errors++; $display("FAIL cool_count got %0d want 2", n_acq); end
    endtask

    task automatic test_ignored;
        logic [3:0] enc [3];
        enc[0] = 4'h0; enc[1] = 4'h3; enc[2] = 4'hC;
        for (int e = 0; e < 3; e++) begin
            bus.core_mem_ctrl = {4{enc[e]}};
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++; if ({bus.busy, bus.ram_we, bus.core_acq} !== 6'b0)
                    begin errors++; $display("FAIL ign_%h busy/we/acq got %b%b%b want 0/0/0000", enc[e], bus.busy, bus.ram_we, bus.core_acq); end
            end
        end
        bus.core_mem_ctrl = '0;
    endtask

    task automatic test_reset_mid;
        bus.core_mem_ctrl[11:8] = 4'h1;
        bus.core_addr[23:16]    = 8'h30;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_rwait_busy got %b want 1", bus.busy); end
        #2 RST = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rmid_we got %b want 0", bus.ram_we); end
        checks++; if (bus.ram_addr !== 8'h00) begin errors++; $display("FAIL rmid_addr got %h want 00", bus.ram_addr); end
        checks++; if (bus.core_ddin !== 32'h0) begin errors++; $display("FAIL rmid_ddin got %h want 0", bus.core_ddin); end
        tick();
        checks++; if (bus.core_acq !== 4'b0000) begin errors++; $display("FAIL rmid_acq got %b want 0000", bus.core_acq); end
        bus.core_mem_ctrl[3:0] = 4'h1;
        bus.core_addr[7:0]     = 8'h40;
        RST = 1'b0;
        tick();
        bus.core_mem_ctrl = '0;
        tick();
        checks++; if (bus.core_acq !== 4'b0000) begin errors++; $display("FAIL rmid_t2_acq got %b want 0000", bus.core_acq); end
        tick();
        checks++; if (bus.core_acq !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant got %b want 0001", bus.core_acq); end
        checks++; if (bus.core_ddin[7:0] !== 8'h33) begin errors++; $display("FAIL rmid_ddin0 got %h want 33", bus.core_ddin[7:0]); end
    endtask

    initial begin
        bus.core_mem_ctrl = '0;
        bus.core_addr     = '0;
        bus.core_wdata    = '0;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_cooldown();
        test_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
